// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared definitions for the round-robin channel multiplexer.
//   MODE_*     : encodings of the 2-bit mode input (2'd3 behaves as MODE_RR)
//   calc_selw  : width of a channel index for an N-channel mux, never below 1
package rr_mux_pkg;

  localparam logic [1:0] MODE_RR    = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_FORCE = 2'd2;

  // A single-channel mux still needs a 1-bit index port.
  function automatic int calc_selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational grant selection plus the round-robin pointer.
//   clk, reset : rising-edge clock, synchronous active-high reset (ptr -> 0)
//   req        : per-channel request (in_valid of the mux)
//   mode       : MODE_RR / MODE_FIXED / MODE_FORCE; 2'd3 behaves as MODE_RR
//   force_sel  : channel granted in forced mode (no grant if >= N)
//   advance    : a transfer happens this cycle; moves ptr in round-robin mode
//   grant      : one-hot (or zero) grant
//   grant_idx  : encoded index of the granted channel (0 when no grant)
module rr_arbiter_n
  import rr_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int DELAY = 0,
  localparam int SELW = calc_selw(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] force_sel,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  // DELAY only matters to gate-level simulation models; the RTL carries none.
  if (N < 1 || DELAY < 0) begin : g_param_check
    $error("rr_arbiter_n: N must be >= 1 and DELAY must be >= 0");
  end

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_base;
  logic            w_rr_mode;
  logic            w_found;

  assign w_rr_mode = (mode != MODE_FIXED) && (mode != MODE_FORCE);
  // Fixed priority is round-robin with the scan always starting at channel 0.
  assign w_base    = w_rr_mode ? r_ptr : '0;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    if (mode == MODE_FORCE) begin
      // With one channel the select input is ignored: grant follows req.
      for (int i = 0; i < N; i++) begin
        if (N == 1 || int'(force_sel) == i) grant[i] = req[i];
      end
    end else begin
      // Two-pass scan: channels base..N-1 first, then the wrap 0..base-1.
      // NOTE: w_found is a blocking in-process flag; it must update
      // immediately so later loop iterations see the earlier winner.
      for (int i = 0; i < N; i++) begin
        if (!w_found && req[i] && i >= int'(w_base)) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!w_found && req[i] && i < int'(w_base)) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = SELW'(i);
    end
  end

  // The channel after the winner becomes the first one scanned next time.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && w_rr_mode) begin
      r_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + SELW'(1);
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-input, WIDTH-bit registered channel mux with valid/ready on
// every input and on the output.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   in_data    : channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   : channel i has data
//   in_ready   : channel i transfers this cycle when in_valid[i] & in_ready[i]
//   mode       : 0 round-robin, 1 fixed priority, 2 forced, 3 as round-robin
//   force_sel  : channel index used in forced mode
//   out_data   : registered data of the selected channel
//   out_src    : index of the channel that produced out_data
//   out_valid  : output register holds data
//   out_ready  : consumer accepts when out_valid & out_ready
module rr_mux_n
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int DELAY = 0,
  localparam int SELW = calc_selw(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [1:0]         mode,
  input  logic [SELW-1:0]    force_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_src;
  logic             r_valid;

  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_grant_idx;
  logic             w_load;
  logic             w_any;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  // The register can take new data when empty or being drained this cycle.
  assign w_load = ~r_valid | out_ready;
  assign w_any  = |w_grant;
  assign w_xfer = w_load & w_any & ~reset;

  // No channel is acknowledged in a reset cycle.
  assign in_ready = w_grant & {N{w_load & ~reset}};

  rr_arbiter_n #(
    .N     (N),
    .DELAY (DELAY)
  ) u_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .mode      (mode),
    .force_sel (force_sel),
    .advance   (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // AND-OR select: ungranted lanes are masked to zero, so X on an idle
  // channel cannot reach the output register.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_src   <= w_grant_idx;
      end else begin
        // Drained with nothing to replace it: data and source are kept.
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: self-checking bench for rr_mux_n, one 4-channel and one
// 3-channel instance sharing clock and reset, each shadowed by a
// cycle-level reference model.
module tb_rr_mux_n;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;

  // 4-channel instance
  logic [4*W-1:0] in_data4;
  logic [3:0]     in_valid4;
  logic [3:0]     in_ready4;
  logic [1:0]     mode4;
  logic [1:0]     fsel4;
  logic [W-1:0]   out_data4;
  logic [1:0]     out_src4;
  logic           out_valid4;
  logic           out_ready4;

  // 3-channel instance
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     mode3;
  logic [1:0]     fsel3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic           out_valid3;
  logic           out_ready3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic         m4_valid, m3_valid;
  logic [W-1:0] m4_data, m3_data;
  int           m4_src, m3_src;
  int           m4_ptr, m3_ptr;

  // in_ready as seen just before the last edge, and what the model expected
  logic [3:0] obs_ready4, exp_ready4;
  logic [2:0] obs_ready3, exp_ready3;

  always #5 clk = ~clk;

  rr_mux_n #(.WIDTH(W), .N(4), .DELAY(0)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .mode(mode4), .force_sel(fsel4),
    .out_data(out_data4), .out_src(out_src4), .out_valid(out_valid4),
    .out_ready(out_ready4)
  );

  rr_mux_n #(.WIDTH(W), .N(3), .DELAY(0)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .force_sel(fsel3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  // Winner under the selection rules; -1 when nobody is granted.
  function automatic int ref_grant(int n, logic [3:0] v, logic [1:0] m, int fsel, int p);
    if (n == 1) return v[0] ? 0 : -1;
    if (m == 2'd1) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
      return -1;
    end
    if (m == 2'd2) return (fsel < n && v[fsel]) ? fsel : -1;
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  // Advance one clock: inputs are already driven (at a negedge); record the
  // handshake, step the models at the edge, return at the next negedge.
  task automatic step();
    int g4, g3;
    logic ld4, ld3;
    logic [W-1:0] d4, d3;
    #1;
    ld4 = !m4_valid || out_ready4;
    ld3 = !m3_valid || out_ready3;
    g4 = ref_grant(4, in_valid4, mode4, int'(fsel4), m4_ptr);
    g3 = ref_grant(3, {1'b0, in_valid3}, mode3, int'(fsel3), m3_ptr);
    exp_ready4 = (!reset && ld4 && g4 >= 0) ? 4'(1 << g4) : 4'b0;
    exp_ready3 = (!reset && ld3 && g3 >= 0) ? 3'(1 << g3) : 3'b0;
    obs_ready4 = in_ready4;
    obs_ready3 = in_ready3;
    d4 = (g4 >= 0) ? in_data4[g4*W +: W] : '0;
    d3 = (g3 >= 0) ? in_data3[g3*W +: W] : '0;
    @(posedge clk);
    if (reset) begin
      m4_valid = 0; m4_data = '0; m4_src = 0; m4_ptr = 0;
      m3_valid = 0; m3_data = '0; m3_src = 0; m3_ptr = 0;
    end else begin
      if (ld4) begin
        if (g4 >= 0) begin
          m4_valid = 1; m4_data = d4; m4_src = g4;
          if (mode4 != 2'd1 && mode4 != 2'd2) m4_ptr = (g4 + 1) % 4;
        end else m4_valid = 0;
      end
      if (ld3) begin
        if (g3 >= 0) begin
          m3_valid = 1; m3_data = d3; m3_src = g3;
          if (mode3 != 2'd1 && mode3 != 2'd2) m3_ptr = (g3 + 1) % 3;
        end else m3_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_lanes4();
    for (int i = 0; i < 4; i++) in_data4[i*W +: W] = W'(64'hA0 + i);
  endtask

  task automatic test_reset();
    reset = 1;
    in_valid4 = 4'b1111; in_valid3 = 3'b111;
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if (obs_ready4 !== 4'b0 || obs_ready3 !== 3'b0) begin
        n_fail++;
        $display("FAIL reset_in_ready c%0d: got %b/%b required 0000/000", c, obs_ready4, obs_ready3);
      end
      n_tests++;
      if (out_valid4 !== 1'b0 || out_data4 !== '0 || out_src4 !== 2'd0 || out_valid3 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: got v=%b d=%h s=%0d v3=%b required 0/0/0/0",
                 c, out_valid4, out_data4, out_src4, out_valid3);
      end
    end
    reset = 0;
    step();
    n_tests++;
    if (obs_ready4 !== 4'b0001 || out_src4 !== 2'd0 || out_valid4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: got ready=%b src=%0d v=%b required 0001/0/1",
               obs_ready4, out_src4, out_valid4);
    end
  endtask

  task automatic test_rr_fairness();
    reset = 1; step(); reset = 0;
    in_valid4 = 4'b1111; out_ready4 = 1; mode4 = 2'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++;
      if (out_valid4 !== 1'b1 || out_src4 !== 2'(k % 4) || out_data4 !== W'(64'hA0 + k % 4)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got v=%b src=%0d data=%h required 1/%0d/%h",
                 k, out_valid4, out_src4, out_data4, k % 4, 64'hA0 + k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    reset = 1; step(); reset = 0;
    in_valid4 = 4'b0100; in_data4[2*W +: W] = 64'hDEAD; out_ready4 = 1;
    step();
    n_tests++;
    if (out_src4 !== 2'd2 || out_data4 !== 64'hDEAD) begin
      n_fail++;
      $display("FAIL bp_first_load: got src=%0d data=%h required 2/dead", out_src4, out_data4);
    end
    set_lanes4();
    out_ready4 = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid4 = 4'($urandom_range(1, 15));
      step();
      n_tests++;
      if (obs_ready4 !== 4'b0 || out_valid4 !== 1'b1 || out_data4 !== 64'hDEAD || out_src4 !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ready=%b v=%b data=%h src=%0d required 0000/1/dead/2",
                 c, obs_ready4, out_valid4, out_data4, out_src4);
      end
    end
    in_valid4 = 4'b1111; out_ready4 = 1;
    step();
    n_tests++;
    if (obs_ready4 !== 4'b1000 || out_src4 !== 2'd3 || out_data4 !== 64'hA3) begin
      n_fail++;
      $display("FAIL bp_release: got ready=%b src=%0d data=%h required 1000/3/a3",
               obs_ready4, out_src4, out_data4);
    end
  endtask

  task automatic test_fixed();
    mode4 = 2'd1; in_valid4 = 4'b1010; out_ready4 = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (out_src4 !== 2'd1 || out_data4 !== 64'hA1 || out_valid4 !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_low[%0d]: got src=%0d data=%h required 1/a1", c, out_src4, out_data4);
      end
    end
    in_valid4 = 4'b1000;
    step();
    n_tests++;
    if (out_src4 !== 2'd3 || out_data4 !== 64'hA3) begin
      n_fail++;
      $display("FAIL fixed_drop: got src=%0d data=%h required 3/a3", out_src4, out_data4);
    end
  endtask

  task automatic test_forced();
    mode4 = 2'd2; fsel4 = 2'd2; in_valid4 = 4'b0111; out_ready4 = 1;
    step();
    n_tests++;
    if (obs_ready4 !== 4'b0100 || out_src4 !== 2'd2 || out_data4 !== 64'hA2) begin
      n_fail++;
      $display("FAIL forced_sel: got ready=%b src=%0d data=%h required 0100/2/a2",
               obs_ready4, out_src4, out_data4);
    end
    in_valid4 = 4'b0011;
    step();
    n_tests++;
    if (obs_ready4 !== 4'b0 || out_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_idle: got ready=%b v=%b required 0000/0", obs_ready4, out_valid4);
    end
  endtask

  task automatic test_n3_wrap_and_reset();
    mode3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1;
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = W'(64'hB0 + i);
    reset = 1; step(); reset = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (out_valid3 !== 1'b1 || out_src3 !== 2'(k % 3) || out_data3 !== W'(64'hB0 + k % 3)) begin
        n_fail++;
        $display("FAIL n3_wrap[%0d]: got v=%b src=%0d data=%h required 1/%0d/%h",
                 k, out_valid3, out_src3, out_data3, k % 3, 64'hB0 + k % 3);
      end
    end
    reset = 1;
    step();
    n_tests++;
    if (out_valid3 !== 1'b0 || obs_ready3 !== 3'b0) begin
      n_fail++;
      $display("FAIL n3_mid_reset: got v=%b ready=%b required 0/000", out_valid3, obs_ready3);
    end
    reset = 0;
    step();
    n_tests++;
    if (out_src3 !== 2'd0 || obs_ready3 !== 3'b001) begin
      n_fail++;
      $display("FAIL n3_ptr_reset: got src=%0d ready=%b required 0/001", out_src3, obs_ready3);
    end
  endtask

  // Random traffic; idle lanes carry X to show it never reaches out_data.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      in_valid4 = 4'($urandom); in_valid3 = 3'($urandom);
      mode4 = 2'($urandom); mode3 = 2'($urandom);
      fsel4 = 2'($urandom); fsel3 = 2'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0); out_ready3 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        in_data4[i*W +: W] = in_valid4[i] ? {$urandom, $urandom} : 'x;
      for (int i = 0; i < 3; i++)
        in_data3[i*W +: W] = in_valid3[i] ? {$urandom, $urandom} : 'x;
      step();
      n_tests++;
      if (obs_ready4 !== exp_ready4 || obs_ready3 !== exp_ready3) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b/%b required %b/%b",
                 c, obs_ready4, obs_ready3, exp_ready4, exp_ready3);
      end
      n_tests++;
      if (out_valid4 !== m4_valid || out_data4 !== m4_data || out_src4 !== 2'(m4_src)) begin
        n_fail++;
        $display("FAIL rand_out4[%0d]: got v=%b d=%h s=%0d required v=%b d=%h s=%0d",
                 c, out_valid4, out_data4, out_src4, m4_valid, m4_data, m4_src);
      end
      n_tests++;
      if (out_valid3 !== m3_valid || out_data3 !== m3_data || out_src3 !== 2'(m3_src)) begin
        n_fail++;
        $display("FAIL rand_out3[%0d]: got v=%b d=%h s=%0d required v=%b d=%h s=%0d",
                 c, out_valid3, out_data3, out_src3, m3_valid, m3_data, m3_src);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    m4_valid = 0; m4_data = '0; m4_src = 0; m4_ptr = 0;
    m3_valid = 0; m3_data = '0; m3_src = 0; m3_ptr = 0;
    mode4 = 2'd0; fsel4 = 2'd0; out_ready4 = 1; in_valid4 = 4'b0;
    mode3 = 2'd0; fsel3 = 2'd0; out_ready3 = 1; in_valid3 = 3'b0;
    set_lanes4();
    in_data3 = '0;
    @(negedge clk);

    test_reset();
    in_valid3 = 3'b0;
    test_rr_fairness();
    test_backpressure();
    test_fixed();
    test_forced();
    in_valid4 = 4'b0;
    test_n3_wrap_and_reset();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
